uarttx_outfifo_design: RTL and testbench
========================================

// Module: uarttx_outfifo_design
// PURPOSE
//  Self-contained accumulator-to-UART streaming block.
//  - A start pulse reads DEPTH stimulus words from an internal ROM and runs them through a per-lane accumulator.
//  - Results are buffered in an output FIFO.
//  - A transmit_en pulse drains the FIFO over an 8N1 UART TX line, 3 bytes per word.
//  - Sits between on-chip test stimulus and an external UART receiver.
// PARAMETERS
//  W            6   bits per accumulator lane
//  Wc           4   number of lanes; word width DW = Wc*W = 24
//  DEPTH        10  number of ROM stimulus words streamed per start
//  ADDRESSWIDTH 4   ROM/FIFO address width; FIFO depth = 2**ADDRESSWIDTH = 16
//  CLKS_PER_BIT 87  clk_in1 cycles per UART bit
// PORTS
//  clk_in1         in   1  single system clock, all logic on rising edge
//  allrst          in   1  synchronous active-high reset
//  start           in   1  rising edge launches a ROM->accumulator->FIFO pass
//  transmit_en     in   1  rising edge launches the FIFO drain over UART
//  o_Tx_Serial     out  1  UART line; idle high
//  o_Tx_Active     out  1  high while a UART byte frame is on the line
//  outfifo_full    out  1  FIFO holds 16 entries
//  transmit_Ready  out  1  high when the drain engine is idle
// BEHAVIOUR
//  Reset values:
//  - Reset (allrst=1 at a clk_in1 edge) empties the FIFO, clears the accumulator and aborts any pass or drain, including mid-frame.
//  - Outputs after reset: o_Tx_Serial=1, o_Tx_Active=0, outfifo_full=0, transmit_Ready=1.
//  Edge detection:
//  - start and transmit_en are edge-detected against their previous-cycle value.
//  - Held levels do not retrigger.
//  ROM:
//  - Entry i (0..DEPTH-1) = {Wc lanes each = i[W-1:0]}.
//  - Contents are fixed at synthesis.
//  Pass:
//  - When start's rising edge is detected at cycle k, ROM addresses 0..9 are read at cycles k+1..k+10.
//  - Registered ROM data reaches the accumulator one cycle later.
//  - Accumulator output is written to the FIFO at cycles k+3..k+12 (valid strobe = write enable).
//  - A start edge during an active pass is ignored.
//  Accumulator:
//  - Per lane: acc <= acc + x, modulo 2**W (wraps, no saturation).
//  - Output word = updated acc.
//  - acc is not cleared between passes; only allrst clears it.
//  FIFO:
//  - Synchronous, first-word fall-through not required.
//  - Write when full is dropped; FIFO contents are unchanged.
//  - Read when empty is impossible because the drain engine checks for empty.
//  - Simultaneous read and write is allowed; count is unchanged.
//  - outfifo_full = (count==16).
//  - Pointers wrap mod 16.
//  Drain FSM:
//  - States: IDLE -> POP -> SEND_B0 -> SEND_B1 -> SEND_B2 -> POP ...
//  - IDLE: transmit_Ready=1.
//  - A transmit_en edge with the FIFO non-empty moves IDLE -> POP; transmit_Ready drops the next cycle.
//  - A transmit_en edge with the FIFO empty is ignored.
//  - POP: read one word and enter SEND_B0.
//  - Send order per word: byte0=y[7:0], then y[15:8], then y[23:16].
//  - After SEND_B2, return to POP if the FIFO is non-empty, else to IDLE.
//  - The transition to IDLE occurs when the last stop bit completes.
//  - Words written during a drain are also sent.
//  UART TX, per byte:
//  - Frame: start bit 0, 8 data bits LSB first, stop bit 1, each CLKS_PER_BIT cycles.
//  - o_Tx_Active=1 from the first cycle of the start bit to the end of data bit 7; 0 during the stop bit.
//  - Frame length is 10*87 = 870 cycles; consecutive bytes are back-to-back.
//  - No parity, no flow control.
// TESTING
//  T1: reset then idle -> o_Tx_Serial=1, o_Tx_Active=0, outfifo_full=0, transmit_Ready=1 for 1000 cycles.
//  T2: start pulse, then transmit_en pulse.
//  - UART receiver (87 clk/bit) gets 30 bytes, per lane sums 0,1,3,6,10,15,21,28,36,45.
//  - Word 3 = 0x186186 -> bytes 0x86,0x61,0x18.
//  - Word 9 (lanes=45=0x2D) = 0xB6DB6D -> bytes 0x6D,0xDB,0xB6.
//  - transmit_Ready returns to 1 after byte 30's stop bit and stays 1.
//  T3: second start without drain.
//  - Accumulation continues (next lane values 45,46,48,...,90 mod 64 = 26).
//  - After the pass, FIFO count = 16 and outfifo_full=1; the 4 extra writes are dropped.
//  T4: transmit_en with the FIFO empty -> transmit_Ready stays 1 and o_Tx_Serial stays 1.
//  T5: allrst asserted mid-byte during a drain.
//  - Next cycle o_Tx_Serial=1 and transmit_Ready=1.
//  - FIFO is empty and the accumulator is 0.
//  - A fresh start gives byte0 = 0x00.
//  T6: start held high for 50 cycles -> exactly one pass (10 FIFO writes).

Source files
------------

// File: rtl/uarttx_outfifo_design.sv
// -----------------------------------------------------------------------------
// uarttx_outfifo_design
//
// Accumulator-to-UART streaming block. A start edge streams DEPTH stimulus
// words out of a fixed ROM through a per-lane wrapping accumulator and into a
// 16-entry output FIFO. A transmit_en edge drains the FIFO over an 8N1 UART
// line, three bytes per word, least significant byte first.
//
// Ports
//   clk_in1         in   system clock, everything on the rising edge
//   allrst          in   synchronous active-high reset
//   start           in   rising edge launches a ROM -> accumulator -> FIFO pass
//   transmit_en     in   rising edge launches the FIFO drain over UART
//   o_Tx_Serial     out  UART line, idles high
//   o_Tx_Active     out  high from start bit through data bit 7 of a frame
//   outfifo_full    out  FIFO holds 2**ADDRESSWIDTH entries
//   transmit_Ready  out  drain engine idle
// -----------------------------------------------------------------------------
module uarttx_outfifo_design #(
   parameter int W            = 6,
   parameter int Wc           = 4,
   parameter int DEPTH        = 10,
   parameter int ADDRESSWIDTH = 4,
   parameter int CLKS_PER_BIT = 87
) (
   input  logic clk_in1,
   input  logic allrst,
   input  logic start,
   input  logic transmit_en,
   output logic o_Tx_Serial,
   output logic o_Tx_Active,
   output logic outfifo_full,
   output logic transmit_Ready
);

   localparam int DW         = Wc * W;
   localparam int FIFO_DEPTH = 2 ** ADDRESSWIDTH;
   localparam int CW         = $clog2(CLKS_PER_BIT);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_POP,
      ST_SEND_B0,
      ST_SEND_B1,
      ST_SEND_B2
   } state_t;

   // ---------------------------------------------------------------------
   // Input edge detection
   // ---------------------------------------------------------------------
   logic start_prev_q, start_prev_d;
   logic tx_prev_q,    tx_prev_d;
   logic start_rise, tx_rise;

   assign start_prev_d = start;
   assign tx_prev_d    = transmit_en;
   assign start_rise   = start & ~start_prev_q;
   assign tx_rise      = transmit_en & ~tx_prev_q;

   // ---------------------------------------------------------------------
   // Pass controller: walks ROM addresses 0..DEPTH-1, one per cycle
   // ---------------------------------------------------------------------
   logic                    pass_active_q, pass_active_d;
   logic [ADDRESSWIDTH-1:0] rom_addr_q,    rom_addr_d;

   always_comb begin
      pass_active_d = pass_active_q;
      rom_addr_d    = rom_addr_q;
      if (pass_active_q) begin
         if (rom_addr_q == ADDRESSWIDTH'(DEPTH - 1)) begin
            pass_active_d = 1'b0;
         end else begin
            rom_addr_d = rom_addr_q + 1'b1;
         end
      end else if (start_rise) begin
         // start edges seen while a pass runs fall through this branch unused
         pass_active_d = 1'b1;
         rom_addr_d    = '0;
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus ROM: entry i replicates i in every lane. The table is a pure
   // function of the address, so it is generated rather than stored.
   // ---------------------------------------------------------------------
   logic [DW-1:0] rom_data_q, rom_data_d;
   logic          rom_valid_q, rom_valid_d;

   assign rom_valid_d = pass_active_q;

   for (genvar gi = 0; gi < Wc; gi++) begin : g_rom_lane
      assign rom_data_d[gi*W +: W] = W'(rom_addr_q);
   end

   // ---------------------------------------------------------------------
   // Per-lane accumulator, wraps modulo 2**W. Only reset clears it.
   // ---------------------------------------------------------------------
   logic [DW-1:0] acc_q, acc_d;
   logic          acc_valid_q, acc_valid_d;

   assign acc_valid_d = rom_valid_q;

   for (genvar gi = 0; gi < Wc; gi++) begin : g_acc_lane
      assign acc_d[gi*W +: W] = rom_valid_q ? (acc_q[gi*W +: W] + rom_data_q[gi*W +: W])
                                            : acc_q[gi*W +: W];
   end

   // ---------------------------------------------------------------------
   // Output FIFO. acc_valid_q is the write strobe and acc_q holds the
   // freshly updated sum in that same cycle.
   // ---------------------------------------------------------------------
   logic [DW-1:0]           fifo_mem [FIFO_DEPTH];
   logic [DW-1:0]           rd_word_q;
   logic [ADDRESSWIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDRESSWIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDRESSWIDTH:0]   count_q,  count_d;
   logic                    fifo_full, fifo_empty;
   logic                    fifo_wr, fifo_rd;
   state_t                  state_q, state_d;

   assign fifo_full  = (count_q == (ADDRESSWIDTH+1)'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);
   // Writes into a full FIFO are dropped outright, leaving contents intact.
   assign fifo_wr    = acc_valid_q & ~fifo_full;
   // POP is only ever entered with the FIFO non-empty.
   assign fifo_rd    = (state_q == ST_POP);

   always_comb begin
      wr_ptr_d = fifo_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = fifo_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
      unique case ({fifo_wr, fifo_rd})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage and registered read port, no reset so it maps onto block RAM.
   always_ff @(posedge clk_in1) begin
      if (fifo_wr) begin
         fifo_mem[wr_ptr_q] <= acc_q;
      end
      if (fifo_rd) begin
         rd_word_q <= fifo_mem[rd_ptr_q];
      end
   end

   // ---------------------------------------------------------------------
   // Drain FSM with embedded 8N1 transmitter.
   // bit_idx: 0 = start bit, 1..8 = data bits LSB first, 9 = stop bit.
   // ---------------------------------------------------------------------
   logic [3:0]    bit_idx_q, bit_idx_d;
   logic [CW-1:0] clk_cnt_q, clk_cnt_d;

   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      clk_cnt_d = clk_cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (tx_rise && !fifo_empty) begin
               state_d = ST_POP;
            end
         end
         ST_POP: begin
            state_d   = ST_SEND_B0;
            bit_idx_d = '0;
            clk_cnt_d = '0;
         end
         default: begin
            if (clk_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
               clk_cnt_d = '0;
               if (bit_idx_q == 4'd9) begin
                  bit_idx_d = '0;
                  unique case (state_q)
                     ST_SEND_B0: state_d = ST_SEND_B1;
                     ST_SEND_B1: state_d = ST_SEND_B2;
                     // count_d includes a word landing this very cycle, so
                     // words written during the drain are not stranded.
                     default:    state_d = (count_d == '0) ? ST_IDLE : ST_POP;
                  endcase
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
      endcase
   end

   // Line outputs are registered from the next-state values so the serial
   // line, the active flag and transmit_Ready all change on the same edge
   // as the state they describe.
   logic       sending_d;
   logic [7:0] tx_byte_d;
   logic [2:0] data_sel_d;
   logic       tx_serial_q, tx_serial_d;
   logic       tx_active_q, tx_active_d;
   logic       ready_q,     ready_d;

   always_comb begin
      sending_d  = (state_d == ST_SEND_B0) || (state_d == ST_SEND_B1) ||
                   (state_d == ST_SEND_B2);
      data_sel_d = 3'(bit_idx_d - 4'd1);
      unique case (state_d)
         ST_SEND_B1: tx_byte_d = rd_word_q[15:8];
         ST_SEND_B2: tx_byte_d = rd_word_q[23:16];
         default:    tx_byte_d = rd_word_q[7:0];
      endcase
      // The start bit of byte0 is driven during POP, before rd_word_q is
      // loaded; it does not depend on the data so that is harmless.
      if (!sending_d) begin
         tx_serial_d = 1'b1;
      end else if (bit_idx_d == 4'd0) begin
         tx_serial_d = 1'b0;
      end else if (bit_idx_d == 4'd9) begin
         tx_serial_d = 1'b1;
      end else begin
         tx_serial_d = tx_byte_d[data_sel_d];
      end
      tx_active_d = sending_d && (bit_idx_d != 4'd9);
      ready_d     = (state_d == ST_IDLE);
   end

   // ---------------------------------------------------------------------
   // Control and datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_in1) begin
      if (allrst) begin
         start_prev_q  <= 1'b0;
         tx_prev_q     <= 1'b0;
         pass_active_q <= 1'b0;
         rom_addr_q    <= '0;
         rom_data_q    <= '0;
         rom_valid_q   <= 1'b0;
         acc_q         <= '0;
         acc_valid_q   <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         state_q       <= ST_IDLE;
         bit_idx_q     <= '0;
         clk_cnt_q     <= '0;
         tx_serial_q   <= 1'b1;
         tx_active_q   <= 1'b0;
         ready_q       <= 1'b1;
      end else begin
         start_prev_q  <= start_prev_d;
         tx_prev_q     <= tx_prev_d;
         pass_active_q <= pass_active_d;
         rom_addr_q    <= rom_addr_d;
         rom_data_q    <= rom_data_d;
         rom_valid_q   <= rom_valid_d;
         acc_q         <= acc_d;
         acc_valid_q   <= acc_valid_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         state_q       <= state_d;
         bit_idx_q     <= bit_idx_d;
         clk_cnt_q     <= clk_cnt_d;
         tx_serial_q   <= tx_serial_d;
         tx_active_q   <= tx_active_d;
         ready_q       <= ready_d;
      end
   end

   assign o_Tx_Serial    = tx_serial_q;
   assign o_Tx_Active    = tx_active_q;
   assign outfifo_full   = fifo_full;
   assign transmit_Ready = ready_q;

endmodule

// File: tb/tb_uarttx_outfifo_design.sv
// -----------------------------------------------------------------------------
// Bench for uarttx_outfifo_design: a behavioural model pushes expected UART
// bytes into a queue as passes are launched; a serial receiver decodes the
// line into a second queue and the scenario tasks compare the two.
// -----------------------------------------------------------------------------
module tb_uarttx_outfifo_design;

   localparam int CPB = 87;

   logic clk = 1'b0;
   logic allrst = 1'b1;
   logic start = 1'b0;
   logic transmit_en = 1'b0;
   logic o_Tx_Serial, o_Tx_Active, outfifo_full, transmit_Ready;

   int errors = 0;
   int checks = 0;

   byte unsigned exp_q[$];
   byte unsigned rx_q[$];

   logic [5:0] macc = '0;
   int         model_cnt = 0;
   int         rst_count = 0;

   uarttx_outfifo_design dut (
      .clk_in1        (clk),
      .allrst         (allrst),
      .start          (start),
      .transmit_en    (transmit_en),
      .o_Tx_Serial    (o_Tx_Serial),
      .o_Tx_Active    (o_Tx_Active),
      .outfifo_full   (outfifo_full),
      .transmit_Ready (transmit_Ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (allrst) rst_count++;

   // Serial receiver: mid-bit sampling; frames touched by a reset are dropped.
   int         mon_rc;
   logic [7:0] mon_b;
   logic       mon_ok;
   initial begin
      forever begin
         @(negedge o_Tx_Serial);
         mon_rc = rst_count;
         repeat (CPB/2) @(negedge clk);
         mon_ok = (o_Tx_Serial === 1'b0);
         if (mon_ok && rst_count == mon_rc) begin
            checks++;
            if (o_Tx_Active !== 1'b1) begin
               errors++;
               $display("FAIL active_in_start_bit got=%b exp=1", o_Tx_Active);
            end
         end
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            mon_b[i] = o_Tx_Serial;
         end
         repeat (CPB) @(negedge clk);
         if (mon_ok && rst_count == mon_rc) begin
            checks++;
            if ({o_Tx_Serial, o_Tx_Active} !== 2'b10) begin
               errors++;
               $display("FAIL stop_bit serial/active got=%b%b exp=10", o_Tx_Serial, o_Tx_Active);
            end
            rx_q.push_back(mon_b);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic pulse_tx();
      @(negedge clk) transmit_en = 1'b1;
      @(negedge clk) transmit_en = 0;
   endtask

   // One pass of the reference: lanes accumulate i mod 64 for i = 0..9.
   task automatic model_pass();
      logic [23:0] w;
      for (int i = 0; i < 10; i++) begin
         macc = macc + 6'(i);
         if (model_cnt < 16) begin
            model_cnt++;
            w = {4{macc}};
            exp_q.push_back(w[7:0]);
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[23:16]);
         end
      end
   endtask

   task automatic model_reset();
      macc = '0;
      model_cnt = 0;
      exp_q.delete();
   endtask

   task automatic wait_bytes(input int n, input string name);
      int cyc = 0;
      while (rx_q.size() < n && cyc < n * 900 + 500) begin
         tick(1);
         cyc++;
      end
      checks++;
      if (rx_q.size() < n) begin
         errors++;
         $display("FAIL %s timeout bytes got=%0d exp=%0d", name, rx_q.size(), n);
      end
   endtask

   task automatic compare_bytes(input int n, input string name);
      byte unsigned g, e;
      for (int i = 0; i < n; i++) begin
         if (rx_q.size() == 0 || exp_q.size() == 0) break;
         g = rx_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL %s byte%0d got=%02h exp=%02h", name, i, g, e);
         end
      end
   endtask

   task automatic wait_ready(input string name);
      int cyc = 0;
      while (transmit_Ready !== 1'b1 && cyc < 2000) begin
         tick(1);
         cyc++;
      end
      checks++;
      if (transmit_Ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_timeout got=%b exp=1", name, transmit_Ready);
      end
   endtask

   task automatic check_idle_for(input int n, input string name);
      for (int i = 0; i < n; i++) begin
         tick(1);
         checks++;
         if ({o_Tx_Serial, o_Tx_Active, transmit_Ready} !== 3'b101) begin
            errors++;
            $display("FAIL %s cyc%0d serial/active/ready got=%b%b%b exp=101",
                     name, i, o_Tx_Serial, o_Tx_Active, transmit_Ready);
         end
      end
   endtask

   // T1
   task automatic test_reset();
      allrst = 1'b1;
      tick(3);
      allrst = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         tick(1);
         checks++;
         if ({o_Tx_Serial, o_Tx_Active, outfifo_full, transmit_Ready} !== 4'b1001) begin
            errors++;
            $display("FAIL reset_idle cyc%0d outs got=%b%b%b%b exp=1001", i,
                     o_Tx_Serial, o_Tx_Active, outfifo_full, transmit_Ready);
         end
      end
   endtask

   // T2
   task automatic test_pass_drain();
      byte unsigned got[30];
      byte unsigned e;
      pulse_start();
      model_pass();
      tick(20);
      checks++;
      if (outfifo_full !== 1'b0) begin
         errors++;
         $display("FAIL pass_full got=%b exp=0", outfifo_full);
      end
      @(negedge clk) transmit_en = 1'b1;
      @(negedge clk) transmit_en = 1'b0;
      checks++;
      if (transmit_Ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_drop got=%b exp=0", transmit_Ready);
      end
      wait_bytes(30, "drain30");
      for (int i = 0; i < 30; i++) begin
         got[i] = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx;
         e      = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
         checks++;
         if (got[i] !== e) begin
            errors++;
            $display("FAIL drain30 byte%0d got=%02h exp=%02h", i, got[i], e);
         end
      end
      model_cnt = 0;
      checks++;
      if ({got[9], got[10], got[11]} !== 24'h866118) begin
         errors++;
         $display("FAIL word3 got=%02h%02h%02h exp=866118", got[9], got[10], got[11]);
      end
      checks++;
      if ({got[27], got[28], got[29]} !== 24'h6DDBB6) begin
         errors++;
         $display("FAIL word9 got=%02h%02h%02h exp=6DDBB6", got[27], got[28], got[29]);
      end
      wait_ready("drain30");
      check_idle_for(500, "after_drain");
   endtask

   // T4
   task automatic test_empty_tx();
      pulse_tx();
      check_idle_for(200, "empty_tx");
      checks++;
      if (rx_q.size() != 0) begin
         errors++;
         $display("FAIL empty_tx rx_bytes got=%0d exp=0", rx_q.size());
      end
   endtask

   // T3
   task automatic test_fill();
      pulse_start();
      model_pass();
      tick(20);
      checks++;
      if (outfifo_full !== 1'b0) begin
         errors++;
         $display("FAIL fill_after_pass1 full got=%b exp=0", outfifo_full);
      end
      pulse_start();
      model_pass();
      tick(20);
      checks++;
      if (outfifo_full !== 1'b1) begin
         errors++;
         $display("FAIL fill_after_pass2 full got=%b exp=1", outfifo_full);
      end
      // Oldest two words must survive the dropped writes.
      pulse_tx();
      wait_bytes(6, "fill_head");
      compare_bytes(6, "fill_head");
   endtask

   task automatic reset_mid_byte(input string name);
      tick(300);
      @(negedge clk) allrst = 1'b1;
      @(negedge clk) allrst = 1'b0;
      checks++;
      if ({o_Tx_Serial, o_Tx_Active, outfifo_full, transmit_Ready} !== 4'b1001) begin
         errors++;
         $display("FAIL %s outs got=%b%b%b%b exp=1001", name,
                  o_Tx_Serial, o_Tx_Active, outfifo_full, transmit_Ready);
      end
      model_reset();
      tick(1000);
      checks++;
      if (rx_q.size() != 0) begin
         errors++;
         $display("FAIL %s stray_bytes got=%0d exp=0", name, rx_q.size());
      end
      rx_q.delete();
   endtask

   // T5
   task automatic test_reset_mid_byte();
      reset_mid_byte("rst_mid1");
      // FIFO must be empty: a drain request is ignored
      pulse_tx();
      check_idle_for(100, "rst_empty");
      pulse_start();
      model_pass();
      tick(20);
      pulse_tx();
      wait_bytes(3, "rst_fresh");
      checks++;
      if (rx_q.size() == 0 || rx_q[0] !== 8'h00) begin
         errors++;
         $display("FAIL rst_fresh byte0 got=%02h exp=00", (rx_q.size() != 0) ? rx_q[0] : 8'hxx);
      end
      compare_bytes(3, "rst_fresh");
      reset_mid_byte("rst_mid2");
   endtask

   // T6
   task automatic test_held_start();
      @(negedge clk) start = 1'b1;
      tick(50);
      start = 1'b0;
      model_pass();
      tick(20);
      pulse_tx();
      wait_bytes(30, "held");
      compare_bytes(30, "held");
      model_cnt = 0;
      wait_ready("held");
      check_idle_for(2000, "held_tail");
      checks++;
      if (rx_q.size() != 0) begin
         errors++;
         $display("FAIL held extra_bytes got=%0d exp=0", rx_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_pass_drain();
      test_empty_tx();
      test_fill();
      test_reset_mid_byte();
      test_held_start();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
